// File: rtl/harmonic_mixer.sv
// Harmonic mixer: scales each upstream sine sample by a decaying level and
// comb gain, accumulates one mix per period and emits it saturated to 16 bits.
module harmonic_mixer #(
    parameter int HARMONIC_MAX = 200,
    parameter int LUT_LATENCY  = 1,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_SHIFT    = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Start,
    input  logic [7:0]  i_Harmonic_Count,
    input  logic [15:0] i_Decay,
    input  logic [15:0] i_Comb,
    input  logic        i_Sample_Ready,
    input  logic [15:0] i_Sample_Value,
    input  logic        i_Freq_Too_High,
    output logic [7:0]  o_Harmonic,
    output logic        o_Next_Sample,
    output logic [15:0] o_Mix,
    output logic        o_Mix_Valid,
    output logic        o_Overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        LATENCY,
        MULT,
        ACC,
        ACK,
        OUTPUT
    } state_t;

    localparam int LW = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(LUT_LATENCY - 1);
    localparam logic [7:0] IDX_LAST = 8'(HARMONIC_MAX - 1);
    localparam logic signed [ACC_WIDTH-1:0] MIX_MAX = 32767;
    localparam logic signed [ACC_WIDTH-1:0] MIX_MIN = -32768;

    state_t                       state;
    logic [LW-1:0]                lat_cnt;
    logic [7:0]                   count;
    logic [15:0]                  level;
    logic                         last;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  term;

    logic [15:0]                  comb_hi;
    logic [15:0]                  decay_hi;
    logic [15:0]                  eff;
    logic signed [32:0]           product;
    logic signed [16:0]           term_w;
    logic                         last_w;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [15:0]                  sat;

    assign comb_hi  = 16'((32'(level) * 32'(i_Comb)) >> 16);
    assign decay_hi = 16'((32'(level) * 32'(i_Decay)) >> 16);
    // Odd indices are the even harmonic numbers and get the comb gain.
    assign eff      = o_Harmonic[0] ? comb_hi : level;
    assign product  = $signed(i_Sample_Value) * $signed({1'b0, eff});
    assign term_w   = 17'(product >>> 16);

    assign last_w = ({1'b0, o_Harmonic} + 9'd1 == {1'b0, count})
                  || i_Freq_Too_High
                  || (o_Harmonic == IDX_LAST);

    assign shifted = acc >>> OUT_SHIFT;

    always_comb begin
        sat = shifted[15:0];
        if (shifted > MIX_MAX)
            sat = 16'h7FFF;
        else if (shifted < MIX_MIN)
            sat = 16'h8000;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            count         <= 8'd1;
            level         <= 16'hFFFF;
            last          <= 1'b0;
            acc           <= '0;
            term          <= '0;
            o_Harmonic    <= 8'd0;
            o_Next_Sample <= 1'b0;
            o_Mix         <= 16'd0;
            o_Mix_Valid   <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            o_Mix_Valid <= 1'b0;
            o_Overrun   <= i_Start && (state != IDLE);
            case (state)
                IDLE: begin
                    o_Harmonic <= 8'd0;
                    acc        <= '0;
                    level      <= 16'hFFFF;
                    lat_cnt    <= '0;
                    count      <= (i_Harmonic_Count == 8'd0) ?
                                  8'd1 : i_Harmonic_Count;
                    if (i_Start)
                        state <= WAIT_READY;
                end
                WAIT_READY: begin
                    lat_cnt <= '0;
                    if (i_Sample_Ready)
                        state <= LATENCY;
                end
                LATENCY: begin
                    if (lat_cnt == LAT_LAST)
                        state <= MULT;
                    else
                        lat_cnt <= lat_cnt + LW'(1);
                end
                MULT: begin
                    term  <= {{(ACC_WIDTH-17){term_w[16]}}, term_w};
                    state <= ACC;
                end
                ACC: begin
                    acc           <= acc + term;
                    level         <= decay_hi;
                    o_Next_Sample <= 1'b1;
                    last          <= last_w;
                    o_Harmonic    <= last_w ? 8'd0 : o_Harmonic + 8'd1;
                    state         <= ACK;
                end
                ACK: begin
                    if (!i_Sample_Ready) begin
                        o_Next_Sample <= 1'b0;
                        state         <= last ? OUTPUT : WAIT_READY;
                    end
                end
                OUTPUT: begin
                    o_Mix       <= sat;
                    o_Mix_Valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Self-checking bench for harmonic_mixer: plays the upstream LUT stage and
// compares every mix against an arithmetic reference model.
module tb_harmonic_mixer;

    localparam int OSH  = 0;
    localparam int HMAX = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_Start;
    logic [7:0]  i_Harmonic_Count;
    logic [15:0] i_Decay;
    logic [15:0] i_Comb;
    logic        i_Sample_Ready;
    logic [15:0] i_Sample_Value;
    logic        i_Freq_Too_High;
    logic [7:0]  o_Harmonic;
    logic        o_Next_Sample;
    logic [15:0] o_Mix;
    logic        o_Mix_Valid;
    logic        o_Overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_ovr   = 0;
    logic [15:0] smp [0:255];

    always #5 clk = ~clk;

    harmonic_mixer #(
        .HARMONIC_MAX (HMAX),
        .LUT_LATENCY  (1),
        .ACC_WIDTH    (32),
        .OUT_SHIFT    (OSH)
    ) dut (
        .i_Clock          (clk),
        .i_Reset_n        (rst_n),
        .i_Start          (i_Start),
        .i_Harmonic_Count (i_Harmonic_Count),
        .i_Decay          (i_Decay),
        .i_Comb           (i_Comb),
        .i_Sample_Ready   (i_Sample_Ready),
        .i_Sample_Value   (i_Sample_Value),
        .i_Freq_Too_High  (i_Freq_Too_High),
        .o_Harmonic       (o_Harmonic),
        .o_Next_Sample    (o_Next_Sample),
        .o_Mix            (o_Mix),
        .o_Mix_Valid      (o_Mix_Valid),
        .o_Overrun        (o_Overrun)
    );

    always @(negedge clk) begin
        if (o_Mix_Valid) n_valid++;
        if (o_Overrun) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int n, input int dec,
                                          input int cmb);
        longint acc = 0;
        longint lvl = 65535;
        longint eff, s;
        for (int k = 0; k < n; k++) begin
            eff = (k % 2 == 1) ? ((lvl * cmb) >> 16) : lvl;
            s   = longint'($signed(smp[k]));
            acc = acc + ((s * eff) >>> 16);
            lvl = (lvl * dec) >> 16;
        end
        acc = acc >>> OSH;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    task automatic run_period(input int cnt, input int dec, input int cmb,
                              input int fth_idx, input int hold,
                              input bit ovr, input bit fixed,
                              input logic [15:0] fval, input int lit);
        int n, v0, o0, wc;
        logic [15:0] exp;
        n = (cnt == 0) ? 1 : cnt;
        if (fth_idx + 1 < n) n = fth_idx + 1;
        if (n > HMAX) n = HMAX;
        for (int k = 0; k < 256; k++)
            smp[k] = fixed ? fval : 16'($urandom);
        exp = model(n, dec, cmb);
        i_Harmonic_Count = 8'(cnt);
        i_Decay = 16'(dec);
        i_Comb = 16'(cmb);
        v0 = n_valid;
        o0 = n_ovr;
        @(negedge clk) i_Start = 1'b1;
        @(negedge clk) i_Start = 1'b0;
        i_Harmonic_Count = 8'($urandom);
        if (ovr) begin
            i_Start = 1'b1;
            @(negedge clk) i_Start = 1'b0;
            check("overrun", 32'(o_Overrun), 1);
        end
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("harm_idx", 32'(o_Harmonic), k);
            i_Sample_Ready = 1'b1;
            i_Freq_Too_High = (k == fth_idx);
            @(negedge clk) i_Sample_Value = smp[k];
            wc = 0;
            while (!o_Next_Sample && wc < 50) begin
                @(negedge clk);
                wc++;
            end
            check("ack_seen", 32'(o_Next_Sample), 1);
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                check("ack_hold", 32'(o_Next_Sample), 1);
            end
            i_Sample_Ready = 1'b0;
            i_Freq_Too_High = 1'b0;
            i_Sample_Value = 16'($urandom);
            @(negedge clk);
            check("ack_drop", 32'(o_Next_Sample), 0);
        end
        check("harm_wrap", 32'(o_Harmonic), 0);
        @(negedge clk);
        check("valid", 32'(o_Mix_Valid), 1);
        check("mix", 32'(o_Mix), 32'(exp));
        if (lit >= 0) check("mix_lit", 32'(o_Mix), lit);
        @(negedge clk);
        check("valid_pulse", 32'(o_Mix_Valid), 0);
        i_Sample_Ready = 1'b1;
        repeat (4) @(negedge clk);
        check("no_capture", 32'(o_Next_Sample), 0);
        i_Sample_Ready = 1'b0;
        @(negedge clk);
        check("valid_count", n_valid - v0, 1);
        check("ovr_count", n_ovr - o0, ovr ? 1 : 0);
    endtask

    initial begin
        int wc, v0;
        rst_n = 1'b0;
        i_Start = 1'b0;
        i_Harmonic_Count = 8'd1;
        i_Decay = 16'hFFFF;
        i_Comb = 16'hFFFF;
        i_Sample_Ready = 1'b0;
        i_Sample_Value = 16'd0;
        i_Freq_Too_High = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mix", 32'(o_Mix), 0);
        check("rst_valid", 32'(o_Mix_Valid), 0);
        check("rst_ack", 32'(o_Next_Sample), 0);
        check("rst_harm", 32'(o_Harmonic), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", n_valid, 0);

        run_period(1, 16'h1234, 16'h5678, 999, 0, 0, 1, 16'h4000, 16'h3FFF);
        run_period(3, 16'h8000, 16'h0000, 999, 1, 0, 1, 16'h4000, 16'h4FFE);
        run_period(10, 16'hF000, 16'hC000, 2, 0, 0, 0, 16'h0, -1);
        run_period(4, 16'hFFFF, 16'hFFFF, 999, 0, 0, 1, 16'h7FFF, 16'h7FFF);
        run_period(4, 16'hFFFF, 16'hFFFF, 999, 0, 0, 1, 16'h8000, 16'h8000);
        run_period(5, 16'hE000, 16'h9000, 999, 5, 1, 0, 16'h0, -1);
        run_period(0, 16'hFFFF, 16'hFFFF, 999, 0, 0, 1, 16'h4000, 16'h3FFF);
        run_period(250, 16'hFFFF, 16'h8000, 999, 0, 0, 0, 16'h0, -1);
        for (int r = 0; r < 12; r++)
            run_period($urandom_range(0, 12), $urandom_range(0, 65535),
                       $urandom_range(0, 65535),
                       ($urandom_range(0, 3) == 0) ?
                       $urandom_range(0, 8) : 999,
                       $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                       0, 16'h0, -1);

        i_Harmonic_Count = 8'd5;
        @(negedge clk) i_Start = 1'b1;
        @(negedge clk) i_Start = 1'b0;
        i_Sample_Ready = 1'b1;
        @(negedge clk) i_Sample_Value = 16'h3000;
        wc = 0;
        while (!o_Next_Sample && wc < 50) begin
            @(negedge clk);
            wc++;
        end
        check("mid_ack", 32'(o_Next_Sample), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ack", 32'(o_Next_Sample), 0);
        check("async_harm", 32'(o_Harmonic), 0);
        check("async_mix", 32'(o_Mix), 0);
        check("async_valid", 32'(o_Mix_Valid), 0);
        check("async_ovr", 32'(o_Overrun), 0);
        @(negedge clk) i_Sample_Ready = 1'b0;
        v0 = n_valid;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        i_Sample_Ready = 1'b1;
        repeat (4) @(negedge clk);
        i_Sample_Ready = 1'b0;
        check("post_rst_ack", 32'(o_Next_Sample), 0);
        check("post_rst_valid", n_valid - v0, 0);
        run_period(3, 16'h8000, 16'h0000, 999, 0, 0, 1, 16'h4000, 16'h4FFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
